// File: rtl/gf180mcu_osu_sc_gp12t3v3_crc_serial.sv
// ============================================================================
// gf180mcu_osu_sc_gp12t3v3_crc_serial : bit-serial Galois CRC generator/checker
// Revision: 1.0
// ============================================================================
`default_nettype none

module gf180mcu_osu_sc_gp12t3v3_crc_serial #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h07),
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(8'h00),
    parameter int               CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             dvalid,
    input  logic             last,
    output logic [WIDTH-1:0] crc,
    output logic [CNTW-1:0]  bitcnt,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t           state;
    logic             fb;
    logic [WIDTH-1:0] crc_next;

    always_comb begin
        fb       = crc[WIDTH-1] ^ din;
        crc_next = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            crc    <= INIT;
            bitcnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            match  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        crc    <= INIT;
                        bitcnt <= '0;
                        match  <= 1'b0;
                        ovf    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (dvalid) begin
                        crc <= crc_next;
                        if (bitcnt == CNT_MAX) begin
                            ovf <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + CNTW'(1);
                        end
                        // DONE and MATCH become visible together with the final CRC
                        if (last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (crc_next == '0);
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3_crc_serial.sv
// Scoreboard bench: two instances (CNTW=16 and CNTW=4) share the same stimulus.
`default_nettype none

module tb_gf180mcu_osu_sc_gp12t3v3_crc_serial;

    localparam logic [7:0] POLY = 8'h07;
    localparam logic [7:0] INIT = 8'h00;
    localparam logic [8:0] GEN  = {1'b1, POLY};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        din = 1'b0;
    logic        dvalid = 1'b0;
    logic        last = 1'b0;
    logic [7:0]  crc_a, crc_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic        busy_a, done_a, match_a, ovf_a;
    logic        busy_b, done_b, match_b, ovf_b;

    gf180mcu_osu_sc_gp12t3v3_crc_serial #(
        .WIDTH(8), .POLY(POLY), .INIT(INIT), .CNTW(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .dvalid(dvalid), .last(last),
        .crc(crc_a), .bitcnt(cnt_a), .busy(busy_a), .done(done_a), .match(match_a), .ovf(ovf_a)
    );

    gf180mcu_osu_sc_gp12t3v3_crc_serial #(
        .WIDTH(8), .POLY(POLY), .INIT(INIT), .CNTW(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .dvalid(dvalid), .last(last),
        .crc(crc_b), .bitcnt(cnt_b), .busy(busy_b), .done(done_b), .match(match_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] crc;
        int         n;
        logic       match;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: polynomial long division of the message (INIT folded into the leading bits)
    function automatic logic [7:0] ref_crc(input bit msg[$]);
        bit         a[$];
        logic [7:0] r;
        a = msg;
        repeat (8) a.push_back(1'b0);
        for (int i = 0; i < 8; i++) a[i] = a[i] ^ INIT[7-i];
        for (int i = 0; i < msg.size(); i++)
            if (a[i])
                for (int j = 0; j <= 8; j++) a[i+j] = a[i+j] ^ GEN[8-j];
        for (int j = 0; j < 8; j++) r[7-j] = a[msg.size()+j];
        return r;
    endfunction

    // Monitor: every DONE pops one expectation
    always @(negedge clk) begin
        if (rst_n && (done_a || done_b)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done_a=%0b done_b=%0b want no pulse", done_a, done_b);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_a", done_a, 1);
                check("done_b", done_b, 1);
                check("latency", cyc, e.due);
                check("crc_a", crc_a, e.crc);
                check("crc_b", crc_b, e.crc);
                check("cnt_a", cnt_a, e.n);
                check("cnt_b", cnt_b, (e.n > 15) ? 15 : e.n);
                check("match_a", match_a, e.match);
                check("match_b", match_b, e.match);
                check("ovf_a", ovf_a, 0);
                check("ovf_b", ovf_b, (e.n > 15) ? 1 : 0);
                check("busy_fin", {busy_a, busy_b}, 0);
            end
        end
    end

    task automatic send(input bit msg[$], input bit noisy);
        exp_t e;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_run", {busy_a, busy_b}, 2'b11);
        for (int i = 0; i < msg.size(); i++) begin
            if (noisy) begin
                while ($urandom_range(0, 2) == 0) begin
                    dvalid = 1'b0;
                    last   = 1'($urandom_range(0, 1));
                    start  = 1'($urandom_range(0, 1));
                    din    = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            dvalid = 1'b1;
            din    = msg[i];
            last   = (i == msg.size() - 1);
            start  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (last) begin
                e.crc   = ref_crc(msg);
                e.n     = msg.size();
                e.match = (e.crc == 8'h00);
                e.due   = cyc + 1;
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        // FIN cycle: everything here must be ignored
        dvalid = noisy;
        last   = noisy;
        start  = noisy;
        @(posedge clk); #1;
        start = 1'b0;
        // IDLE: DVALID/LAST must not disturb the held results
        repeat (2) @(posedge clk);
        #1 dvalid = 1'b0;
        last = 1'b0;
        if (noisy) begin
            check("hold_crc", crc_a, e.crc);
            check("hold_cnt", cnt_a, e.n);
        end
    endtask

    task automatic drain;
        int k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic push_byte(inout bit q[$], input logic [7:0] v);
        for (int b = 7; b >= 0; b--) q.push_back(v[b]);
    endtask

    initial begin
        bit    msg[$];
        string s;
        logic [7:0] ch;

        #12;
        check("reset_a", {crc_a, cnt_a, busy_a, done_a, match_a, ovf_a}, {INIT, 16'h0, 4'h0});
        check("reset_b", {crc_b, cnt_b, busy_b, done_b, match_b, ovf_b}, {INIT, 4'h0, 4'h0});
        @(negedge clk) rst_n = 1'b1;

        // Reset mid-frame after 5 bits
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dvalid = 1'b1;
            din    = 1'b1;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1 check("midreset_a", {crc_a, cnt_a, busy_a, done_a, match_a, ovf_a}, {INIT, 16'h0, 4'h0});
        dvalid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single bit
        msg.delete();
        msg.push_back(1'b1);
        send(msg, 1'b0);
        drain();
        check("single_crc", crc_a, 8'h07);

        // "123456789"
        s = "123456789";
        msg.delete();
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            push_byte(msg, ch);
        end
        send(msg, 1'b0);
        drain();
        check("check_value", crc_a, 8'hF4);

        // Same with gaps and unqualified START/LAST
        send(msg, 1'b1);
        drain();
        check("noisy_value", {crc_a, cnt_a}, {8'hF4, 16'd72});

        // Residue check
        push_byte(msg, 8'hF4);
        send(msg, 1'b0);
        drain();
        check("residue", {crc_a, match_a, cnt_a}, {8'h00, 1'b1, 16'd80});

        // 20-bit frame saturates the 4-bit counter
        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(1'($urandom_range(0, 1)));
        send(msg, 1'b0);
        drain();
        check("sat_b", {cnt_b, ovf_b}, {4'd15, 1'b1});

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 40);
            if (n == 15) n = 16;
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(1'($urandom_range(0, 1)));
            send(msg, 1'($urandom_range(0, 1)));
            drain();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
